// File: rtl/id_hazard_scoreboard.sv
// Decode-stage scoreboard: per-register writeback countdowns drive the stall
// request and gate issue into ID/EX. Optional stall counter under HAZARD_PERF_CNT_EN.
module id_hazard_scoreboard #(
  parameter int unsigned WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic        id_use_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        flush,
  input  logic        mem_freeze,
  output logic        hazard,
  output logic        issue,
  output logic [14:0] busy_mask
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = $clog2(WB_LAT + 1);
  localparam logic [3:0]  PC_REG   = 4'd15;

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [15:0]      busy_ext;
  logic             src1_busy;
  logic             src2_busy;
  logic             load_dest;

  // Busy view of the register file; R15 is padded in as never busy.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
    busy_ext = {1'b0, busy_mask};
  end

  assign src1_busy = id_use_src1 & busy_ext[id_src1];
  assign src2_busy = id_two_src  & busy_ext[id_src2];
  assign hazard    = id_valid & (src1_busy | src2_busy);
  assign issue     = id_valid & ~hazard & ~flush & ~mem_freeze;
  assign load_dest = issue & id_wb_en & (id_dest != PC_REG);

  // Countdown update: freeze holds everything, a new writer reloads its dest.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_nxt[r] = cnt[r];
      if (!mem_freeze) begin
        if (load_dest && (id_dest == 4'(r))) begin
          cnt_nxt[r] = CNT_W'(WB_LAT);
        end else if (cnt[r] != '0) begin
          cnt_nxt[r] = cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (!rst) begin
        cnt[r] <= '0;
      end else begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of cycles actually lost to operand hazards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (hazard && !mem_freeze && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Scoreboard-based hazard controller for the instruction decode stage. Tracks in-flight register writebacks with per-register countdown timers and raises `hazard` to stall fetch/decode while a source operand of the instruction in decode has a pending write. It also gates issue into the ID/EX register on branch flush and memory freeze, and optionally counts stall cycles.

## Interface
Parameters:
- `WB_LAT`, default 3: cycles from issue out of ID until the register file write is visible to a decode read. Legal range 1..7.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  the decode stage holds a real instruction.
- `id_src1`  in  4  first source register (Rn).
- `id_use_src1`  in  1  the instruction reads Rn (0 for MOV/MVN/B).
- `id_src2`  in  4  second source register (Rm, or Rd for STR).
- `id_two_src`  in  1  the instruction reads `id_src2`.
- `id_wb_en`  in  1  the instruction writes a register.
- `id_dest`  in  4  destination register (Rd).
- `flush`  in  1  a taken branch squashes the instruction in decode this cycle.
- `mem_freeze`  in  1  the back-end pipeline is frozen (memory wait).
- `hazard`  out  1  stall request to IF and decode.
- `issue`  out  1  the ID/EX register captures a valid instruction this cycle.
- `busy_mask`  out  15  bit r is 1 while register r has a pending write.
- `stall_cycles`  out  16  stall-cycle counter; only present with the macro.

## Operation
- State: one countdown `cnt[r]` per register r=0..14, width `$clog2(WB_LAT+1)`. R15 (PC) is never tracked.
- `busy_mask[r] = (cnt[r] != 0)`.
- `hazard = id_valid & ((id_use_src1 & busy(id_src1)) | (id_two_src & busy(id_src2)))`, where busy(15) = 0. `hazard` is combinational from state and inputs.
- `issue = id_valid & ~hazard & ~flush & ~mem_freeze`.
- Counter update per cycle when `mem_freeze` = 0:
  - every nonzero `cnt[r]` decrements by 1;
  - if `issue & id_wb_en & id_dest != 15`, then `cnt[id_dest] <= WB_LAT`; this overrides the decrement for that register.
- With `mem_freeze` = 1, all counters hold and nothing issues.
- An instruction whose source equals its own destination has no self-hazard. Hazard is evaluated only against state.
- Two writers to the same register: the later issue reloads the counter to `WB_LAT`.
- `flush` does not clear counters, because instructions already issued still write back.
- `flush` and `hazard` asserted together: the result is no issue, and `hazard` stays as computed.

## Timing
- Reset (`rst`=0 at a clock edge): every `cnt` = 0, `busy_mask` = 0, `stall_cycles` = 0. Consequently `hazard` = 0 and `issue` = `id_valid & ~flush & ~mem_freeze`.
- Reset asserted mid-operation discards all pending writes at that edge.
- Issue at cycle t with destination d:
  - `busy_mask[d]` is 1 during cycles t+1 through t+WB_LAT;
  - `busy_mask[d]` is 0 at t+WB_LAT+1, assuming no freeze;
  - each frozen cycle extends the busy window by one cycle.
- A dependent instruction in decode from cycle t+1 stalls for exactly WB_LAT cycles and issues at t+WB_LAT+1.
- `hazard` to `issue` path: same cycle, no registered latency.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` port exists;
  - it increments by 1 on every cycle with `hazard` = 1 and `mem_freeze` = 0;
  - it saturates at 16'hFFFF and clears on reset.
- `HAZARD_PERF_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset with all inputs 0, then `id_valid`=1, src1=2, `use_src1`=1 → `hazard`=0, `issue`=1, `busy_mask`=0.
- WB_LAT=3; issue ADD R1 at t, then SUB reading R1 in decode from t+1 → `hazard`=1 for t+1..t+3, `issue`=1 at t+4, `stall_cycles`=3.
- Same sequence with `mem_freeze`=1 at t+2 for 2 cycles → `busy_mask[1]` stays 1 through t+5, and the dependent instruction issues at t+6.
- Issue writing R15, then read R15 → `hazard`=0 and `busy_mask` unchanged. Also, `id_two_src`=0 with src2 busy → no hazard.
- Issue R4 at t, issue R4 again at t+1 with unrelated sources → `cnt[4]` reloads to 3, and `busy_mask[4]` clears at t+5.
- `flush`=1 with an `id_wb_en` instruction → `issue`=0 and no counter set. Then `rst`=0 while R3 is busy → `busy_mask`=0 on the next cycle.
